// File: rtl/l1_lookup_lru_ctrl.sv
// l1_lookup_lru_ctrl
// Set-associative L1 lookup controller and initiator side of the LRU update
// handshake. One request at a time: tag compare across all ways, classify as
// hit / fill into an empty way / replace, hand the decision to the LRU block,
// then install the tag and report the resulting way upstream.
// Optional feature: define L1_STATS_EN to build saturating hit/miss/evict
// counters; otherwise the stat_* ports are tied to zero.
`timescale 1ns/1ps

module l1_lookup_lru_ctrl #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    parameter int ADDR_W          = 32,
    localparam int OFFSET_W = $clog2(BLOCK_SIZE_BYTE),
    localparam int SET      = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int SET_W    = $clog2(SET),
    localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W,
    localparam int WAY_W    = (WAY > 1) ? $clog2(WAY) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [4:0]        resp_way,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_evict_tag,
    output logic              lru_start,
    output logic [SET_W-1:0]  lru_index,
    output logic              lru_found,
    output logic              lru_updated,
    output logic              lru_replace,
    output logic [4:0]        lru_way_index,
    input  logic [4:0]        lru_replace_index,
    input  logic              lru_block_replace,
    input  logic              lru_update_done,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_evicts
);

    typedef enum logic [2:0] {
        DRAIN, IDLE, LOOKUP, LRU_REQ, LRU_WAIT, RESP
    } state_t;

    state_t             state;
    logic [5:0]         drain_cnt;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   fill_way_q;

    logic [TAG_W-1:0]   tag_mem   [SET][WAY];
    logic [WAY-1:0]     valid_mem [SET];

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               empty;
    logic [WAY_W-1:0]   empty_way;
    logic [WAY_W-1:0]   victim_way;
    logic               fill_we;

    // Offset bits and the unused high bits of the victim index carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{req_addr[OFFSET_W-1:0], lru_replace_index};

    // Tag compare and lowest-empty-way search over the latched set.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        hit       = 1'b0;
        hit_way   = '0;
        empty     = 1'b0;
        empty_way = '0;
        for (int w = 0; w < WAY; w++) begin
            if (!hit && valid_mem[lru_index][w] && tag_mem[lru_index][w] == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!empty && !valid_mem[lru_index][w]) begin
                empty     = 1'b1;
                empty_way = WAY_W'(w);
            end
        end
    end

    // Way written on completion: LRU victim (or way 0 on a protocol error) when replacing, else the chosen way.
    assign victim_way = lru_replace ? (lru_block_replace ? lru_replace_index[WAY_W-1:0] : '0)
                                    : fill_way_q;
    assign fill_we    = (state == LRU_WAIT) && lru_update_done && !lru_found;

    // Tag storage write on a miss completion.
    always_ff @(posedge clk) begin
        // NOTE: the tag array is not reset; the valid bits alone decide whether an entry is used.
        if (fill_we) begin
            tag_mem[lru_index][victim_way] <= tag_q;
        end
    end

    // Valid bits: cleared by reset, set when a line is installed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET; s++) begin
                valid_mem[s] <= '0;
            end
        end else if (fill_we) begin
            valid_mem[lru_index][victim_way] <= 1'b1;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every read in this block sees pre-edge values.
        if (rst) begin
            state          <= DRAIN;
            drain_cnt      <= '0;
            tag_q          <= '0;
            fill_way_q     <= '0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
            lru_start      <= 1'b0;
            lru_index      <= '0;
            lru_found      <= 1'b0;
            lru_updated    <= 1'b0;
            lru_replace    <= 1'b0;
            lru_way_index  <= '0;
        end else begin
            lru_start  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                DRAIN: begin
                    if (drain_cnt == 6'(WAY + 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 6'd1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        tag_q     <= req_addr[ADDR_W-1 -: TAG_W];
                        lru_index <= req_addr[OFFSET_W +: SET_W];
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        lru_found     <= 1'b1;
                        lru_way_index <= 5'(hit_way) + 5'd1;
                        fill_way_q    <= hit_way;
                    end else if (empty) begin
                        lru_updated <= 1'b1;
                        fill_way_q  <= empty_way;
                    end else begin
                        lru_replace <= 1'b1;
                    end
                    lru_start <= 1'b1;
                    state     <= LRU_REQ;
                end
                LRU_REQ: begin
                    // lru_update_done may still be high from the previous op; ignore it here.
                    state <= LRU_WAIT;
                end
                LRU_WAIT: begin
                    if (lru_update_done) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= lru_found;
                        resp_way   <= 5'(victim_way) + 5'd1;
                        if (lru_replace) begin
                            resp_evict     <= 1'b1;
                            resp_evict_tag <= tag_mem[lru_index][victim_way];
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    resp_hit       <= 1'b0;
                    resp_way       <= '0;
                    resp_evict     <= 1'b0;
                    resp_evict_tag <= '0;
                    lru_found      <= 1'b0;
                    lru_updated    <= 1'b0;
                    lru_replace    <= 1'b0;
                    lru_way_index  <= '0;
                    req_ready      <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    drain_cnt <= '0;
                    req_ready <= 1'b0;
                    state     <= DRAIN;
                end
            endcase
        end
    end

`ifdef L1_STATS_EN
    // Saturating access counters, updated in the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_evicts <= '0;
        end else if (state == RESP) begin
            if (resp_hit && stat_hits != '1) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (!resp_hit && stat_misses != '1) begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (resp_evict && stat_evicts != '1) begin
                stat_evicts <= stat_evicts + 32'd1;
            end
        end
    end
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_evicts = '0;
`endif

endmodule

// File: tb/tb_l1_lookup_lru_ctrl.sv
// tb_l1_lookup_lru_ctrl
// Directed scenarios followed by randomized traffic, each response compared
// against a per-set way/tag table kept in the bench. A behavioural LRU peer
// answers lru_start, keeping lru_update_done high between operations.
`timescale 1ns/1ps

module tb_l1_lookup_lru_ctrl;

    localparam int WAY      = 4;
    localparam int OFFSET_W = 4;
    localparam int SET      = 512;
    localparam int SET_W    = 9;
    localparam int TAG_W    = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic [4:0]        resp_way;
    logic              resp_evict;
    logic [TAG_W-1:0]  resp_evict_tag;
    logic              lru_start;
    logic [SET_W-1:0]  lru_index;
    logic              lru_found;
    logic              lru_updated;
    logic              lru_replace;
    logic [4:0]        lru_way_index;
    logic [4:0]        lru_replace_index;
    logic              lru_block_replace;
    logic              lru_update_done;
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
    logic [31:0]       stat_evicts;

    int n_checks = 0;
    int n_pass   = 0;

    // LRU peer behaviour knobs
    int peer_extra  = 0;
    int peer_victim = 0;
    bit peer_bad    = 1'b0;

    // Reference model: per-set way table
    bit               m_valid [SET][WAY];
    logic [TAG_W-1:0] m_tag   [SET][WAY];

    l1_lookup_lru_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_evict        (resp_evict),
        .resp_evict_tag    (resp_evict_tag),
        .lru_start         (lru_start),
        .lru_index         (lru_index),
        .lru_found         (lru_found),
        .lru_updated       (lru_updated),
        .lru_replace       (lru_replace),
        .lru_way_index     (lru_way_index),
        .lru_replace_index (lru_replace_index),
        .lru_block_replace (lru_block_replace),
        .lru_update_done   (lru_update_done),
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses),
        .stat_evicts       (stat_evicts)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // LRU peer: lowers done one cycle after lru_start, raises it WAY+peer_extra cycles later.
    initial begin
        bit want_victim;
        lru_update_done   = 1'b0;
        lru_block_replace = 1'b0;
        lru_replace_index = '0;
        forever begin
            @(posedge clk); #1;
            if (lru_start === 1'b1 && rst === 1'b0) begin
                want_victim = (lru_replace === 1'b1);
                @(posedge clk); #1;
                lru_update_done = 1'b0;
                repeat (WAY + peer_extra) @(posedge clk);
                #1;
                lru_update_done   = 1'b1;
                lru_block_replace = want_victim && !peer_bad;
                lru_replace_index = 5'(peer_victim);
                @(posedge clk); #1;
                lru_block_replace = 1'b0;
                lru_replace_index = 5'($urandom_range(0, 31));
            end
        end
    end

    // Reset for one edge, then confirm the quiet drain window and its exact length.
    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_lru_start", lru_start, 0);
        check("rst_flags", {lru_found, lru_updated, lru_replace}, 0);
        check("rst_evict", {resp_evict, resp_evict_tag}, 0);
        rst = 1'b0;
        for (int s = 0; s < SET; s++)
            for (int w = 0; w < WAY; w++) m_valid[s][w] = 1'b0;
        for (int i = 0; i < WAY + 2; i++) begin
            check("drain_ready", req_ready, 0);
            check("drain_lru_start", lru_start, 0);
            check("drain_resp_valid", resp_valid, 0);
            @(posedge clk); #1;
        end
        check("drain_done_ready", req_ready, 1);
    endtask

    // One complete access, predicted from the way table and checked field by field.
    task automatic do_req(input logic [31:0] addr);
        int idx, h, e, v, lat, starts;
        logic [TAG_W-1:0] tg;
        bit exp_hit, exp_evict;
        logic [2:0] exp_flags, got_flags;
        int exp_way;
        logic [TAG_W-1:0] exp_evict_tag;
        logic [SET_W-1:0] got_index;
        logic [4:0] got_lway;
        bit got;
        idx = int'((addr >> OFFSET_W) % SET);
        tg  = TAG_W'(addr >> (OFFSET_W + SET_W));
        h = -1; e = -1;
        for (int w = 0; w < WAY; w++) begin
            if (h < 0 && m_valid[idx][w] && m_tag[idx][w] == tg) h = w;
            if (e < 0 && !m_valid[idx][w]) e = w;
        end
        exp_evict = 1'b0; exp_evict_tag = '0; exp_hit = 1'b0;
        if (h >= 0) begin
            exp_hit = 1'b1; exp_way = h + 1; exp_flags = 3'b100;
        end else if (e >= 0) begin
            exp_way = e + 1; exp_flags = 3'b010;
            m_valid[idx][e] = 1'b1; m_tag[idx][e] = tg;
        end else begin
            v = peer_bad ? 0 : peer_victim;
            exp_way = v + 1; exp_flags = 3'b001;
            exp_evict = 1'b1; exp_evict_tag = m_tag[idx][v];
            m_tag[idx][v] = tg;
        end

        lat = 0;
        while (req_ready !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;

        lat = 0; starts = 0; got = 1'b0;
        got_flags = '0; got_index = '0; got_lway = '0;
        while (!got && lat < 60) begin
            if (lru_start === 1'b1) begin
                starts++;
                got_flags = {lru_found, lru_updated, lru_replace};
                got_index = lru_index;
                got_lway  = lru_way_index;
            end
            @(posedge clk); #1; lat++;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        check("resp_seen", got, 1);
        check("latency", lat, WAY + 3 + peer_extra);
        check("lru_start_count", starts, 1);
        check("lru_flags", got_flags, exp_flags);
        check("lru_index", got_index, idx);
        if (exp_hit) check("lru_way_index", got_lway, exp_way);
        check("resp_hit", resp_hit, exp_hit);
        check("resp_way", resp_way, exp_way);
        check("resp_evict", resp_evict, exp_evict);
        if (exp_evict) check("resp_evict_tag", resp_evict_tag, exp_evict_tag);
        @(posedge clk); #1;
        check("resp_pulse_end", {resp_valid, resp_evict}, 0);
    endtask

    function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] tg, input int idx, input int off);
        return (32'(tg) << (OFFSET_W + SET_W)) | (32'(idx) << OFFSET_W) | 32'(off);
    endfunction

    initial begin
        logic [TAG_W-1:0] tags [6];
        int sets [4];
        int k;
        tags = '{19'h00000, 19'h7FFFF, 19'h00001, 19'h2AAAA, 19'h55555, 19'h00003};
        sets = '{0, 16, 'h123, SET - 1};
        rst = 1'b1; req_valid = 1'b0; req_addr = '0;
        @(posedge clk); #1;
        apply_reset();

        // Cold miss, then hit on the same line
        do_req(32'h0000_1230);
        do_req(32'h0000_1230);

        // Fill the rest of set 0x123, then replace the third way
        do_req(mk_addr(19'h00011, 'h123, 4));
        do_req(mk_addr(19'h00022, 'h123, 8));
        do_req(mk_addr(19'h00033, 'h123, 15));
        peer_victim = 2;
        do_req(mk_addr(19'h00044, 'h123, 0));
`ifdef L1_STATS_EN
        check("stat_hits", stat_hits, 1);
        check("stat_misses", stat_misses, 5);
        check("stat_evicts", stat_evicts, 1);
`else
        check("stat_tied", {stat_hits, stat_misses, stat_evicts}, 0);
`endif

        // Slow peer: stale done must not complete the op early
        peer_extra = 3;
        do_req(32'h0000_1230);
        peer_extra = 0;

        // Victim missing on a replace: way 0 is evicted
        peer_bad = 1'b1;
        do_req(mk_addr(19'h00055, 'h123, 0));
        peer_bad = 1'b0;

        // Reset while waiting on the LRU block
        req_valid = 1'b1; req_addr = 32'h0000_5670;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (lru_start !== 1'b1 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("abort_lru_start_seen", lru_start, 1);
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        do_req(32'h0000_1230);

        // Randomized traffic over a few sets and a small tag pool
        for (int i = 0; i < 150; i++) begin
            peer_extra  = $urandom_range(0, 2);
            peer_victim = $urandom_range(0, WAY - 1);
            peer_bad    = ($urandom_range(0, 7) == 0);
            do_req(mk_addr(tags[$urandom_range(0, 5)], sets[$urandom_range(0, 3)],
                           $urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
